// File: rtl/vdc_circle_driver.sv
// Van der Corput (base-2) point sequencer: turns a (start_index, num_points)
// request into one-at-a-time CORDIC requests and buffers each result for downstream.
module vdc_circle_driver #(
    parameter int ANGLE_W = 16,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic [IDX_W-1:0]   start_index,
    input  logic [IDX_W-1:0]   num_points,
    output logic               busy,
    output logic               run_done,
    output logic               cordic_start,
    output logic [ANGLE_W-1:0] cordic_angle,
    input  logic               cordic_ready,
    input  logic               cordic_done,
    input  logic [DATA_W-1:0]  cordic_cos,
    input  logic [DATA_W-1:0]  cordic_sin,
    output logic               pt_valid,
    input  logic               pt_ready,
    output logic [DATA_W-1:0]  pt_cos,
    output logic [DATA_W-1:0]  pt_sin,
    output logic [IDX_W-1:0]   pt_index,
    output logic               pt_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t             state_reg;
    logic [IDX_W-1:0]   k_reg;
    logic [IDX_W-1:0]   remaining_reg;
    logic [IDX_W-1:0]   k_next;
    logic [ANGLE_W-1:0] start_angle;
    logic [ANGLE_W-1:0] next_angle;

    assign k_next = k_reg + IDX_ONE;

    // Angle is the bit-reversed index: the van der Corput radical inverse in turns.
    generate
        for (genvar gi = 0; gi < ANGLE_W; gi++) begin : g_bitrev
            assign start_angle[gi] = start_index[IDX_W-1-gi];
            assign next_angle[gi]  = k_next[IDX_W-1-gi];
        end
    endgenerate

    assign busy     = (state_reg != S_IDLE);
    assign pt_valid = (state_reg == S_OUT);
    // Only cordic_ready reaches cordic_start; pt_ready affects it through state alone.
    assign cordic_start = (state_reg == S_ISSUE) && cordic_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            k_reg         <= '0;
            remaining_reg <= '0;
            run_done      <= 1'b0;
            cordic_angle  <= '0;
            pt_cos        <= '0;
            pt_sin        <= '0;
            pt_index      <= '0;
            pt_last       <= 1'b0;
        end else begin
            run_done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (go && (num_points != '0)) begin
                        k_reg         <= start_index;
                        remaining_reg <= num_points;
                        cordic_angle  <= start_angle;
                        state_reg     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cordic_ready) begin
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cordic_done) begin
                        pt_cos    <= cordic_cos;
                        pt_sin    <= cordic_sin;
                        pt_index  <= k_reg;
                        pt_last   <= (remaining_reg == IDX_ONE);
                        state_reg <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (pt_ready) begin
                        k_reg         <= k_next;
                        remaining_reg <= remaining_reg - IDX_ONE;
                        cordic_angle  <= next_angle;
                        if (pt_last) begin
                            run_done  <= 1'b1;
                            state_reg <= S_IDLE;
                        end else begin
                            state_reg <= S_ISSUE;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
